// File: rtl/mac_fold.sv
// mac_fold: folded A*B (+/-E) over B limbs; out_valid N_B+FF_MUL cycles after accept, C held until out_ready.
// Define MAC_FOLD_OVERLAP_EN to allow a new accept on the same edge as the result handoff.
module mac_fold #(
   parameter int LOGA   = 64,
   parameter int LOGB   = 64,
   parameter int LIMB_B = 17,
   parameter int LIMB_A = 26,
   parameter int MODE_E = 0,
   parameter int LOGE   = 64,
   parameter int FF_MUL = 1,
   localparam int LOGC  = (MODE_E == 0) ? (LOGA + LOGB)
                        : (((LOGA + LOGB) > LOGE ? (LOGA + LOGB) : LOGE) + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [LOGA-1:0] A,
   input  logic [LOGB-1:0] B,
   input  logic [LOGE-1:0] E,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [LOGC-1:0] C
);

   localparam int N_B = (LOGB + LIMB_B - 1) / LIMB_B;
   localparam int N_A = (LOGA + LIMB_A - 1) / LIMB_A;
   localparam int AW  = N_A * LIMB_A;
   localparam int BW  = N_B * LIMB_B;
   localparam int PW  = LIMB_A + LIMB_B;
   localparam int RW  = AW + LIMB_B;
   localparam int SW  = (RW > LOGC) ? RW : LOGC;
   localparam int KW  = $clog2(N_B + 1);
   localparam logic [KW-1:0] K_END  = KW'(N_B);
   localparam logic [KW-1:0] K_LAST = KW'(N_B - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nx;

   logic [AW-1:0]     a_reg;
   logic [BW-1:0]     b_reg;
   logic [LOGC-1:0]   acc;
   logic [KW-1:0]     k;
   logic              accept;
   logic              issue;
   logic [LIMB_B-1:0] b_limb;
   logic [LIMB_A-1:0] a_limb;
   logic [PW-1:0]     part;
   logic [RW-1:0]     row;
   logic [RW-1:0]     add_row;
   logic [KW-1:0]     add_k;
   logic              add_vld;
   logic [SW-1:0]     add_shift;
   logic [LOGC-1:0]   e_ext;
   logic [LOGC-1:0]   e_init;

`ifdef MAC_FOLD_OVERLAP_EN
   assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
`else
   assign in_ready = (state == IDLE);
`endif

   assign accept    = in_valid && in_ready;
   assign issue     = (state == RUN) && (k < K_END);
   assign out_valid = (state == DONE);
   assign C         = acc;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (accept) state_nx = RUN;
         RUN:  if (add_vld && (add_k == K_LAST)) state_nx = DONE;
         DONE: begin
            if (out_ready) begin
`ifdef MAC_FOLD_OVERLAP_EN
               state_nx = accept ? RUN : IDLE;
`else
               state_nx = IDLE;
`endif
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // One row of N_A narrow DSP products against the current B limb.
   always_comb begin
      b_limb = LIMB_B'(b_reg >> (int'(k) * LIMB_B));
      a_limb = '0;
      part   = '0;
      row    = '0;
      for (int i = 0; i < N_A; i++) begin
         a_limb = LIMB_A'(a_reg >> (i * LIMB_A));
         part   = PW'(a_limb) * PW'(b_limb);
         row    = row + (RW'(part) << (i * LIMB_A));
      end
   end

   always_comb begin
      e_ext  = LOGC'($signed(E));
      e_init = '0;
      if (MODE_E == 1)      e_init = e_ext;
      else if (MODE_E == 2) e_init = '0 - e_ext;
   end

   generate
      if (FF_MUL != 0) begin : g_pipe
         logic [RW-1:0] row_q;
         logic [KW-1:0] k_q;
         logic          vld_q;
         always_ff @(posedge clk) begin
            if (rst) begin
               row_q <= '0;
               k_q   <= '0;
               vld_q <= 1'b0;
            end else begin
               row_q <= row;
               k_q   <= k;
               vld_q <= issue;
            end
         end
         assign add_row = row_q;
         assign add_k   = k_q;
         assign add_vld = vld_q;
      end else begin : g_comb
         assign add_row = row;
         assign add_k   = k;
         assign add_vld = issue;
      end
   endgenerate

   assign add_shift = SW'(add_row) << (int'(add_k) * LIMB_B);

   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg <= '0;
         b_reg <= '0;
         acc   <= '0;
         k     <= '0;
      end else if (accept) begin
         a_reg <= AW'(A);
         b_reg <= BW'(B);
         acc   <= e_init;
         k     <= '0;
      end else begin
         if (issue)   k   <= k + 1'b1;
         if (add_vld) acc <= acc + add_shift[LOGC-1:0];
      end
   end

endmodule

// File: tb/tb_mac_fold.sv
// Bench for mac_fold: three instances (A*B no pipe, A*B+E with 32-bit E, A*B-E), scoreboard of expected C.
module tb_mac_fold;

`ifdef MAC_FOLD_OVERLAP_EN
   localparam int SPACING = 5;
`else
   localparam int SPACING = 6;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic [63:0]  a, b, e;
   logic [2:0]   in_v, out_r;
   wire  [2:0]   in_r, out_v;
   wire  [127:0] c0;
   wire  [128:0] c1, c2;

   logic [128:0] exp_q[$];
   int cyc = 0;
   int acc_cyc = 0;
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mac_fold #(.MODE_E(0), .FF_MUL(0)) u0 (
      .clk(clk), .rst(rst), .in_valid(in_v[0]), .in_ready(in_r[0]), .A(a), .B(b), .E(e),
      .out_valid(out_v[0]), .out_ready(out_r[0]), .C(c0));
   mac_fold #(.MODE_E(1), .LOGE(32), .FF_MUL(1)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_v[1]), .in_ready(in_r[1]), .A(a), .B(b), .E(e[31:0]),
      .out_valid(out_v[1]), .out_ready(out_r[1]), .C(c1));
   mac_fold #(.MODE_E(2), .FF_MUL(1)) u2 (
      .clk(clk), .rst(rst), .in_valid(in_v[2]), .in_ready(in_r[2]), .A(a), .B(b), .E(e),
      .out_valid(out_v[2]), .out_ready(out_r[2]), .C(c2));

   function automatic logic [128:0] c_of(int idx);
      if (idx == 0)      return {1'b0, c0};
      else if (idx == 1) return c1;
      else               return c2;
   endfunction

   function automatic logic [128:0] model(int idx, logic [63:0] ma, logic [63:0] mb, logic [63:0] me);
      logic [128:0] p;
      p = {65'd0, ma} * {65'd0, mb};
      if (idx == 1)      p = p + {{97{me[31]}}, me[31:0]};
      else if (idx == 2) p = p - {{65{me[63]}}, me};
      else               p[128] = 1'b0;
      return p;
   endfunction

   task automatic send(int idx, logic [63:0] sa, logic [63:0] sb, logic [63:0] se);
      bit ok;
      ok = 1'b0;
      a = sa; b = sb; e = se;
      exp_q.push_back(model(idx, sa, sb, se));
      in_v[idx] = 1'b1;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (in_r[idx]) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         errors++;
         $display("FAIL accept_timeout[%0d]: in_ready never rose", idx);
      end
      @(posedge clk); #1;
      acc_cyc = cyc;
      in_v[idx] = 1'b0;
   endtask

   task automatic wait_out(int idx, output int lat);
      lat = -1;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (out_v[idx]) begin lat = cyc - acc_cyc; break; end
      end
   endtask

   task automatic release_out(int idx);
      @(posedge clk); #1 out_r[idx] = 1'b1;
      @(posedge clk); #1 out_r[idx] = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_v = '0; out_r = '0; a = '0; b = '0; e = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         checks++; if (out_v[i] !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d]: got %b want 0", i, out_v[i]); end
         checks++; if (in_r[i] !== 1'b1) begin errors++; $display("FAIL reset_in_ready[%0d]: got %b want 1", i, in_r[i]); end
         checks++; if (c_of(i) !== 129'd0) begin errors++; $display("FAIL reset_c[%0d]: got %0h want 0", i, c_of(i)); end
      end
   endtask

   task automatic test_max_mul();
      int lat;
      logic [128:0] exp;
      @(posedge clk); #1;
      send(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
      wait_out(0, lat);
      exp = exp_q.pop_front();
      checks++; if (lat !== 4) begin errors++; $display("FAIL max_latency: got %0d want 4", lat); end
      checks++; if (c_of(0) !== exp) begin errors++; $display("FAIL max_c_model: got %0h want %0h", c_of(0), exp); end
      checks++; if (c0 !== 128'hFFFFFFFFFFFFFFFE0000000000000001) begin
         errors++; $display("FAIL max_c_const: got %0h want fffffffffffffffe0000000000000001", c0); end
      release_out(0);
      @(negedge clk);
      checks++; if (out_v[0] !== 1'b0 || in_r[0] !== 1'b1) begin
         errors++; $display("FAIL max_handoff: got out_valid=%b in_ready=%b want 0/1", out_v[0], in_r[0]); end
   endtask

   task automatic test_sub_negative();
      int lat;
      logic [128:0] exp, lit;
      lit = '1;
      lit[7:0] = 8'hFB;
      @(posedge clk); #1;
      send(2, 64'd3, 64'd5, 64'd20);
      wait_out(2, lat);
      exp = exp_q.pop_front();
      checks++; if (lat !== 5) begin errors++; $display("FAIL sub_latency: got %0d want 5", lat); end
      checks++; if (c2 !== exp) begin errors++; $display("FAIL sub_c_model: got %0h want %0h", c2, exp); end
      checks++; if (c2 !== lit) begin errors++; $display("FAIL sub_c_const: got %0h want %0h", c2, lit); end
      release_out(2);
   endtask

   task automatic test_add_negative_e();
      int lat;
      logic [128:0] exp, lit;
      @(posedge clk); #1;
      send(1, 64'd0, 64'd0, 64'h0000_0000_FFFF_FFFF);
      wait_out(1, lat);
      exp = exp_q.pop_front();
      lit = '1;
      checks++; if (lat !== 5) begin errors++; $display("FAIL add_latency: got %0d want 5", lat); end
      checks++; if (c1 !== exp || c1 !== lit) begin errors++; $display("FAIL add_neg_c: got %0h want %0h", c1, lit); end
      release_out(1);
      @(posedge clk); #1;
      send(1, 64'h8000_0000_0000_0000, 64'd2, 64'd1);
      wait_out(1, lat);
      exp = exp_q.pop_front();
      lit = '0;
      lit[64] = 1'b1;
      lit[0]  = 1'b1;
      checks++; if (c1 !== exp || c1 !== lit) begin errors++; $display("FAIL add_pos_c: got %0h want %0h", c1, lit); end
      release_out(1);
   endtask

   task automatic test_backpressure();
      int lat;
      logic [128:0] exp;
      @(posedge clk); #1;
      send(0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'd0);
      wait_out(0, lat);
      exp = exp_q.pop_front();
      for (int n = 0; n < 10; n++) begin
         @(posedge clk); #1;
         a = {$urandom, $urandom}; b = {$urandom, $urandom}; e = {$urandom, $urandom};
         in_v[0] = 1'b1;
         @(negedge clk);
         checks++; if (out_v[0] !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", n, out_v[0]); end
         checks++; if (c_of(0) !== exp) begin errors++; $display("FAIL bp_c[%0d]: got %0h want %0h", n, c_of(0), exp); end
         checks++; if (in_r[0] !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", n, in_r[0]); end
      end
      @(posedge clk); #1;
      in_v[0] = 1'b0; out_r[0] = 1'b1;
      @(posedge clk); #1 out_r[0] = 1'b0;
      @(negedge clk);
      checks++; if (out_v[0] !== 1'b0 || in_r[0] !== 1'b1) begin
         errors++; $display("FAIL bp_release: got out_valid=%b in_ready=%b want 0/1", out_v[0], in_r[0]); end
      repeat (3) @(negedge clk);
      checks++; if (out_v[0] !== 1'b0) begin errors++; $display("FAIL bp_no_second: got out_valid=%b want 0", out_v[0]); end
   endtask

   task automatic test_reset_mid();
      int lat;
      logic [128:0] exp;
      @(posedge clk); #1;
      send(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
      void'(exp_q.pop_back());
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      checks++; if (out_v[0] !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", out_v[0]); end
      checks++; if (c_of(0) !== 129'd0) begin errors++; $display("FAIL midrst_c: got %0h want 0", c_of(0)); end
      checks++; if (in_r[0] !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b want 1", in_r[0]); end
      @(posedge clk); #1;
      send(0, 64'd7, 64'd9, 64'd0);
      wait_out(0, lat);
      exp = exp_q.pop_front();
      checks++; if (lat !== 4) begin errors++; $display("FAIL midrst_latency: got %0d want 4", lat); end
      checks++; if (c_of(0) !== exp || c0 !== 128'd63) begin errors++; $display("FAIL midrst_c63: got %0h want 3f", c0); end
      release_out(0);
   endtask

   task automatic test_back_to_back();
      int got, last;
      logic [128:0] exp;
      got = 0; last = -1;
      @(posedge clk); #1;
      out_r[0] = 1'b1;
      fork
         begin
            for (int j = 0; j < 3; j++)
               send(0, {$urandom, $urandom}, {$urandom, $urandom}, 64'd0);
         end
         begin
            for (int n = 0; n < 200 && got < 3; n++) begin
               @(negedge clk);
               if (out_v[0]) begin
                  exp = exp_q.pop_front();
                  checks++; if (c_of(0) !== exp) begin errors++; $display("FAIL b2b_c[%0d]: got %0h want %0h", got, c_of(0), exp); end
                  if (got > 0) begin
                     checks++; if (cyc - last !== SPACING) begin
                        errors++; $display("FAIL b2b_spacing[%0d]: got %0d want %0d", got, cyc - last, SPACING); end
                  end
                  last = cyc;
                  got++;
               end
            end
         end
      join
      checks++; if (got !== 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", got); end
      @(posedge clk); #1 out_r[0] = 1'b0;
   endtask

   initial begin
      test_reset();
      test_max_mul();
      test_sub_negative();
      test_add_negative_e();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
